// File: rtl/dvi_pkg.sv
// dvi_pkg: shared definitions for the DVI output path.
//   - TMDS control symbols (also used by the per-channel encoders)
//   - rgb_t pixel type, scan controller state enum
//   - default 640x480@60 timing constants
//   - testbar_rgb(): colour of one of the eight vertical test bars
package dvi_pkg;

    // TMDS control symbols, indexed by {c1,c0}
    localparam logic [9:0] CtrlSym00 = 10'b1101010100;
    localparam logic [9:0] CtrlSym01 = 10'b0010101011;
    localparam logic [9:0] CtrlSym10 = 10'b0101010100;
    localparam logic [9:0] CtrlSym11 = 10'b1010101011;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StStopping
    } scan_state_e;

    // 640x480 defaults
    localparam int unsigned DefHActive = 640;
    localparam int unsigned DefHFp     = 16;
    localparam int unsigned DefHSync   = 96;
    localparam int unsigned DefHBp     = 48;
    localparam int unsigned DefVActive = 480;
    localparam int unsigned DefVFp     = 10;
    localparam int unsigned DefVSync   = 2;
    localparam int unsigned DefVBp     = 33;

    // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black
    function automatic rgb_t testbar_rgb(input logic [2:0] bar);
        logic [2:0] on;  // {r,g,b} channel at full scale
        rgb_t       c;
        case (bar)
            3'd0:    on = 3'b111;
            3'd1:    on = 3'b110;
            3'd2:    on = 3'b011;
            3'd3:    on = 3'b010;
            3'd4:    on = 3'b101;
            3'd5:    on = 3'b100;
            3'd6:    on = 3'b001;
            default: on = 3'b000;
        endcase
        c.r = {8{on[2]}};
        c.g = {8{on[1]}};
        c.b = {8{on[0]}};
        return c;
    endfunction

endpackage

// File: rtl/dvi_timing_gen.sv
// dvi_timing_gen: raster counters and region decode.
// Ports:
//   i_clk, i_rst_n    pixel clock, asynchronous active-low reset
//   i_cnt_en          advance the raster position this cycle
//   o_hcnt, o_vcnt    current horizontal / vertical position
//   o_active          position is inside the visible area
//   o_hs, o_vs        position is inside the hsync / vsync interval (unqualified by polarity)
module dvi_timing_gen
    import dvi_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DefHActive,
    parameter int unsigned H_FP     = DefHFp,
    parameter int unsigned H_SYNC   = DefHSync,
    parameter int unsigned H_BP     = DefHBp,
    parameter int unsigned V_ACTIVE = DefVActive,
    parameter int unsigned V_FP     = DefVFp,
    parameter int unsigned V_SYNC   = DefVSync,
    parameter int unsigned V_BP     = DefVBp,
    parameter int unsigned HCNT_W   = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int unsigned VCNT_W   = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cnt_en,
    output logic [HCNT_W-1:0] o_hcnt,
    output logic [VCNT_W-1:0] o_vcnt,
    output logic              o_active,
    output logic              o_hs,
    output logic              o_vs
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic [VCNT_W-1:0] vcnt_q, vcnt_d;
    logic              h_last, v_last;

    always_comb begin
        h_last = (32'(hcnt_q) == H_TOTAL - 1);
        v_last = (32'(vcnt_q) == V_TOTAL - 1);
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (i_cnt_en) begin
            if (h_last) begin
                hcnt_d = '0;
                vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    // Counters are zero-extended so that an interval end equal to 2**W still compares correctly
    assign o_active = (32'(hcnt_q) < H_ACTIVE) && (32'(vcnt_q) < V_ACTIVE);
    assign o_hs     = (32'(hcnt_q) >= HS_START) && (32'(hcnt_q) < HS_END);
    assign o_vs     = (32'(vcnt_q) >= VS_START) && (32'(vcnt_q) < VS_END);
    assign o_hcnt   = hcnt_q;
    assign o_vcnt   = vcnt_q;

endmodule

// File: rtl/dvi_scan_ctrl.sv
// dvi_scan_ctrl: raster scan controller feeding the three TMDS encoders.
// Optional feature macro: DVI_SCAN_TESTPAT_EN (adds i_testpat and an 8-bar colour pattern).
// Ports:
//   i_clk, i_rst_n          pixel clock, asynchronous active-low reset
//   i_enable                run request; a frame in progress always completes
//   i_pix_data/i_pix_valid  {R,G,B} source, consumed when o_pix_ready & i_pix_valid
//   o_pix_ready             combinational: a pixel is taken this cycle
//   o_de                    display enable (registered)
//   o_ctrl                  {vsync,hsync} for the blue encoder, asserted level = V_POL/H_POL
//   o_red/o_green/o_blue    pixel colour (registered)
//   o_frame_start           one-cycle pulse alongside the first pixel of a frame
//   o_underflow             sticky, set when ready but source not valid
//   i_underflow_clr         clears o_underflow (a same-cycle set wins)
//   i_testpat               (DVI_SCAN_TESTPAT_EN only) show bars instead of source data
module dvi_scan_ctrl
    import dvi_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DefHActive,
    parameter int unsigned H_FP     = DefHFp,
    parameter int unsigned H_SYNC   = DefHSync,
    parameter int unsigned H_BP     = DefHBp,
    parameter int unsigned V_ACTIVE = DefVActive,
    parameter int unsigned V_FP     = DefVFp,
    parameter int unsigned V_SYNC   = DefVSync,
    parameter int unsigned V_BP     = DefVBp,
    parameter logic        H_POL    = 1'b0,
    parameter logic        V_POL    = 1'b0,
    parameter logic [23:0] FILL_RGB = 24'h000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
`ifdef DVI_SCAN_TESTPAT_EN
    input  logic        i_testpat,
`endif
    input  logic [23:0] i_pix_data,
    input  logic        i_pix_valid,
    output logic        o_pix_ready,
    output logic        o_de,
    output logic [1:0]  o_ctrl,
    output logic [7:0]  o_red,
    output logic [7:0]  o_green,
    output logic [7:0]  o_blue,
    output logic        o_frame_start,
    output logic        o_underflow,
    input  logic        i_underflow_clr
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HCNT_W  = $clog2(H_TOTAL);
    localparam int unsigned VCNT_W  = $clog2(V_TOTAL);

    scan_state_e       state_q;
    logic [HCNT_W-1:0] hcnt;
    logic [VCNT_W-1:0] vcnt;
    logic              active, hs, vs;
    logic              run, pix_active, frame_end, at_origin, tp_on;
    rgb_t              rgb_q, bar_rgb;

    assign run = (state_q != StIdle);

    // Counters sit at (0,0) while idle, so the first running cycle is pixel (0,0)
    dvi_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HCNT_W   (HCNT_W),
        .VCNT_W   (VCNT_W)
    ) u_timing (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_cnt_en (run),
        .o_hcnt   (hcnt),
        .o_vcnt   (vcnt),
        .o_active (active),
        .o_hs     (hs),
        .o_vs     (vs)
    );

    assign frame_end  = (32'(hcnt) == H_TOTAL - 1) && (32'(vcnt) == V_TOTAL - 1);
    assign at_origin  = (hcnt == '0) && (vcnt == '0);
    assign pix_active = run & active;

`ifdef DVI_SCAN_TESTPAT_EN
    logic tp_q;
    assign tp_on   = tp_q;
    assign bar_rgb = testbar_rgb(3'((32'(hcnt) * 32'd8) / H_ACTIVE));
`else
    assign tp_on   = 1'b0;
    assign bar_rgb = '0;
`endif

    assign o_pix_ready = pix_active & ~tp_on;
    assign o_red       = rgb_q.r;
    assign o_green     = rgb_q.g;
    assign o_blue      = rgb_q.b;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= StIdle;
            o_de          <= 1'b0;
            o_ctrl        <= {~V_POL, ~H_POL};
            rgb_q         <= '0;
            o_frame_start <= 1'b0;
            o_underflow   <= 1'b0;
`ifdef DVI_SCAN_TESTPAT_EN
            tp_q          <= 1'b0;
`endif
        end else begin
            // Enable is only acted on at frame boundaries once running
            case (state_q)
                StIdle: begin
                    if (i_enable) state_q <= StRun;
                end
                StRun: begin
                    if (frame_end)      state_q <= i_enable ? StRun : StIdle;
                    else if (!i_enable) state_q <= StStopping;
                end
                StStopping: begin
                    if (frame_end) state_q <= i_enable ? StRun : StIdle;
                end
                default: state_q <= StIdle;
            endcase

            o_de          <= pix_active;
            o_ctrl        <= {(run & vs) ^ ~V_POL, (run & hs) ^ ~H_POL};
            o_frame_start <= pix_active & at_origin;

            if (o_pix_ready) begin
                rgb_q <= i_pix_valid ? rgb_t'(i_pix_data) : rgb_t'(FILL_RGB);
            end else if (pix_active) begin
                rgb_q <= bar_rgb;  // only reachable while the test pattern is selected
            end else begin
                rgb_q <= '0;
            end

            if (o_pix_ready & ~i_pix_valid) begin
                o_underflow <= 1'b1;
            end else if (i_underflow_clr) begin
                o_underflow <= 1'b0;
            end

`ifdef DVI_SCAN_TESTPAT_EN
            // Latched on the edge that enters pixel (0,0), so a frame never mixes sources
            if (!run || frame_end) tp_q <= i_testpat;
`endif
        end
    end

endmodule

// File: tb/tb_dvi_scan_ctrl.sv
// Bench for dvi_scan_ctrl with a small raster (H 4/1/2/1, V 3/1/1/1, 48 clocks per frame).
// The reference model tracks the raster as a linear frame position and derives every
// expected output from that position and the inputs driven in the same cycle.
module tb_dvi_scan_ctrl;

    localparam int unsigned HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int unsigned VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned FRAME = HT * VT;
    localparam logic [23:0] FILL = 24'h123456;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        valid = 1'b0;
    logic        clr = 1'b0;
    logic        tp = 1'b0;
    logic [23:0] data = '0;
    logic        ready, de, fs, uf;
    logic [1:0]  ctrl;
    logic [7:0]  red, green, blue;

    always #5 clk = ~clk;

    dvi_scan_ctrl #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .H_POL    (1'b0), .V_POL (1'b0), .FILL_RGB (FILL)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_enable        (en),
`ifdef DVI_SCAN_TESTPAT_EN
        .i_testpat       (tp),
`endif
        .i_pix_data      (data),
        .i_pix_valid     (valid),
        .o_pix_ready     (ready),
        .o_de            (de),
        .o_ctrl          (ctrl),
        .o_red           (red),
        .o_green         (green),
        .o_blue          (blue),
        .o_frame_start   (fs),
        .o_underflow     (uf),
        .i_underflow_clr (clr)
    );

    int total = 0;
    int bad = 0;

    // Reference model state
    bit          running = 1'b0;
    int          pos = 0;
    bit          tp_cur = 1'b0;
    bit          e_uf = 1'b0;
    int unsigned data_ctr = 0;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_de"}, 32'(de), 32'd0);
        chk({tag, "_ctrl"}, 32'(ctrl), 32'd3);
        chk({tag, "_rgb"}, {8'd0, red, green, blue}, 32'd0);
        chk({tag, "_ready"}, 32'(ready), 32'd0);
        chk({tag, "_fs"}, 32'(fs), 32'd0);
        chk({tag, "_uf"}, 32'(uf), 32'd0);
    endtask

    // One pixel clock: called just after a falling edge with inputs already driven
    task automatic cyc();
        int          x, y;
        bit          act, hsy, vsy, exp_ready, e_de, e_fs, consumed;
        logic [1:0]  e_ctrl;
        logic [23:0] e_rgb;
        x = pos % HT;
        y = pos / HT;
        act = running && (x < HA) && (y < VA);
        hsy = running && (x >= HA + HF) && (x < HA + HF + HS);
        vsy = running && (y >= VA + VF) && (y < VA + VF + VS);
        exp_ready = act && !tp_cur;
        chk("ready", 32'(ready), 32'(exp_ready));
        e_de = act;
        e_ctrl = {~vsy, ~hsy};
        e_fs = running && (pos == 0);
        if (!act) e_rgb = '0;
        else if (tp_cur) e_rgb = bars[x * 8 / HA];
        else e_rgb = valid ? data : FILL;
        if (exp_ready && !valid) e_uf = 1'b1;
        else if (clr) e_uf = 1'b0;
        consumed = exp_ready && valid;
        @(posedge clk);
        // A running frame always completes; enable is only looked at on its last clock
        if (running) begin
            if (pos == FRAME - 1) begin
                running = en;
                pos = 0;
                tp_cur = tp;
            end else begin
                pos++;
            end
        end else if (en) begin
            running = 1'b1;
            pos = 0;
            tp_cur = tp;
        end
        if (consumed) data_ctr++;
        @(negedge clk);
        chk("de", 32'(de), 32'(e_de));
        chk("ctrl", 32'(ctrl), 32'(e_ctrl));
        chk("rgb", {8'd0, red, green, blue}, {8'd0, e_rgb});
        chk("frame_start", 32'(fs), 32'(e_fs));
        chk("underflow", 32'(uf), 32'(e_uf));
    endtask

    initial begin
        // Reset state while held in reset
        repeat (2) @(negedge clk);
        chk_reset_vals("por");
        rst_n = 1'b1;

        // Idle with enable low: nothing leaves the controller
        repeat (3) cyc();

        // Streaming with an always-valid incrementing source
        en = 1'b1;
        valid = 1'b1;
        for (int i = 0; i < 3 * FRAME + 1; i++) begin
            data = 24'(data_ctr);
            cyc();
        end

        // Underflow at pixel (2,1), then a clear with no underflow, then set+clear together
        for (int i = 0; i < FRAME; i++) begin
            data = 24'(data_ctr);
            valid = !(running && pos == HT + 2);
            cyc();
        end
        valid = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            data = 24'(data_ctr);
            clr = running && (pos == 4 || pos == 2 * HT + 1);
            valid = !(running && pos == 2 * HT + 1);
            cyc();
        end
        clr = 1'b0;
        valid = 1'b1;

        // Enable dropped at (1,1): frame runs out, then idle
        for (int i = 0; i < FRAME + 12; i++) begin
            if (running && pos == HT + 1) en = 1'b0;
            data = 24'(data_ctr);
            cyc();
        end

        // Enable dropped and restored inside a frame: frames stay back to back
        en = 1'b1;
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            if (running && pos == HT + 1) en = 1'b0;
            if (running && pos == 3 * HT + 6) en = 1'b1;
            data = 24'(data_ctr);
            cyc();
        end

        // Randomized source, clear and enable
        for (int i = 0; i < 4 * FRAME; i++) begin
            valid = ($urandom_range(0, 3) != 0);
            data = 24'($urandom);
            clr = ($urandom_range(0, 7) == 0);
            en = ($urandom_range(0, 15) != 0);
            cyc();
        end
        clr = 1'b0;

        // Asynchronous reset mid-line, right after an underflow
        en = 1'b1;
        for (int i = 0; i < 4 * FRAME && !(running && pos == HT + 3); i++) begin
            valid = !(running && pos == HT + 2);
            data = 24'(data_ctr);
            cyc();
        end
        valid = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        running = 1'b0;
        pos = 0;
        tp_cur = 1'b0;
        e_uf = 1'b0;
        en = 1'b0;
        repeat (5) cyc();
        en = 1'b1;
        for (int i = 0; i < FRAME + 2; i++) begin
            data = 24'(data_ctr);
            cyc();
        end

`ifdef DVI_SCAN_TESTPAT_EN
        // Test pattern takes effect from the next frame start
        tp = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            valid = ($urandom_range(0, 1) != 0);
            data = 24'($urandom);
            cyc();
        end
        tp = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
